ids_channel_scheduler: RTL and testbench
========================================

// Module: ids_channel_scheduler
// PURPOSE
//  Time-shares one IDS detection engine (histogram build + chi-squared test + threshold compare) among N_CH CAN channels.
//  Each channel raises a request once a full window of frame bytes is buffered.
//  The scheduler grants channels round-robin, starts the engine, and bounds each run with a watchdog.
//  It routes each verdict back to its channel and filters verdicts into per-channel alarms with hysteresis.
// PARAMETERS
//  N_CH       4      number of requesting channels (>=2)
//  ALARM_K    3      consecutive attack verdicts that set alarm[i]
//  CLEAR_K    2      consecutive clean verdicts that clear alarm[i]
//  TIMEOUT    4096   max cycles from eng_start to eng_done before abort
// PORTS
//  clk         in   1              clock
//  rst         in   1              asynchronous, active-high reset
//  ch_req      in   N_CH           level; channel i has a full window ready
//  ch_gnt      out  N_CH           one-hot; held for the whole service of the granted channel
//  ch_ack      out  N_CH           one-hot 1-cycle pulse; service of channel i finished (verdict or abort)
//  ch_sel      out  $clog2(N_CH)   index of the granted channel; muxes channel data into the engine
//  eng_start   out  1              1-cycle pulse; engine begins a window
//  eng_abort   out  1              1-cycle pulse; engine must return to idle (watchdog)
//  eng_done    in   1              1-cycle pulse; verdict valid
//  eng_attack  in   1              verdict: 1 = chi >= threshold; sampled only with eng_done
//  alarm       out  N_CH           filtered per-channel attack flag
//  fault       out  N_CH           sticky; channel i suffered a timeout
//  fault_clr   in   N_CH           per-bit synchronous clear of fault (ignored while rst)
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE. rr_ptr=0. Per-channel counters=0. alarm=0. fault=0.
//  FSM states: IDLE -> RUN -> POST -> IDLE.
//  IDLE:
//   - if |ch_req: arbiter picks the first requester at or after rr_ptr (wrapping).
//   - Registers ch_sel/ch_gnt. Next cycle: eng_start=1, state=RUN, watchdog=0.
//   - Latency req->eng_start: 1 cycle.
//  RUN:
//   - ch_gnt held; watchdog increments each cycle.
//   - eng_done -> POST, latching eng_attack.
//   - watchdog==TIMEOUT-1 without done -> eng_abort pulse, fault[sel]<=1, state=POST, no verdict.
//   - eng_done in the same cycle as expiry: done wins, no abort, no fault.
//  POST (1 cycle):
//   - ch_ack[sel] pulse; ch_gnt drops; rr_ptr<=sel+1 (wraps at N_CH).
//   - Verdict applied to channel sel only:
//     - attack: atk_cnt sat-increments, clr_cnt=0; atk_cnt reaching ALARM_K sets alarm.
//     - clean: clr_cnt sat-increments, atk_cnt=0; clr_cnt reaching CLEAR_K clears alarm.
//     - counters saturate at their K.
//   - Aborted run leaves counters and alarm unchanged.
//   - POST always returns to IDLE, so back-to-back service has a 1-cycle IDLE gap.
//  ch_req drop during RUN: run completes normally; ack still issued.
//  eng_done outside RUN: ignored, no state change.
//  fault_clr[i] with a simultaneous timeout on i: set wins.
//  Async rst mid-RUN: immediate return to reset state; no eng_abort issued (engine shares rst).
//  Counter widths: $clog2(K+1). Watchdog width: $clog2(TIMEOUT).
// STRUCTURE
//  ids_pkg:
//   - sched_state_e {IDLE,RUN,POST}.
//   - verdict_t {logic valid; logic attack; logic aborted;}.
//   - default-constant localparams.
//  Sub-module rr_arbiter #(N) (req, ptr -> one-hot gnt, idx, any); purely combinational.
//  Top holds the FSM, watchdog, and a per-channel hysteresis counter array (generate loop).
// TESTING
//  1. req=4'b0001, done+attack 10 cycles after start -> start 1 cycle after req; ack[0] in POST; alarm[0]=0.
//  2. req=4'b1111 held, engine done each time -> grant order 0,1,2,3,0; one IDLE cycle between acks.
//  3. ch2 gets 3 attack verdicts -> alarm[2]=1 in POST of 3rd; 1 clean keeps 1; 2nd clean -> alarm[2]=0.
//  4. No eng_done for TIMEOUT cycles -> eng_abort at cycle TIMEOUT after start; fault[sel]=1, alarm unchanged; fault_clr clears it.
//  5. eng_done exactly on expiry cycle -> no abort, no fault, verdict applied.
//  6. rst asserted mid-RUN with alarm[1]=1 -> all outputs 0 asynchronously; next grant starts at ch0.

Source files
------------

// File: rtl/ids_channel_scheduler_pkg.sv
// Shared types and default parameters for the IDS channel scheduler.
// Imported by the interface, the arbiter and the top.
package ids_channel_scheduler_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_ALARM_K = 3;
  localparam int DEF_CLEAR_K = 2;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    POST
  } sched_state_e;

  typedef struct packed {
    logic valid;
    logic attack;
    logic aborted;
  } verdict_t;

endpackage

// File: rtl/ids_channel_scheduler_if.sv
// Channel and engine handshake bundle of the IDS scheduler.
// master = scheduler side, slave = channels/engine side.
interface ids_channel_scheduler_if
  import ids_channel_scheduler_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
);
  localparam int SW = $clog2(N_CH);

  logic [N_CH-1:0] ch_req;
  logic [N_CH-1:0] ch_gnt;
  logic [N_CH-1:0] ch_ack;
  logic [SW-1:0]   ch_sel;
  logic            eng_start;
  logic            eng_abort;
  logic            eng_done;
  logic            eng_attack;
  logic [N_CH-1:0] alarm;
  logic [N_CH-1:0] fault;
  logic [N_CH-1:0] fault_clr;

  modport master (
    input  ch_req, eng_done, eng_attack, fault_clr,
    output ch_gnt, ch_ack, ch_sel,
    output eng_start, eng_abort, alarm, fault
  );

  modport slave (
    output ch_req, eng_done, eng_attack, fault_clr,
    input  ch_gnt, ch_ack, ch_sel,
    input  eng_start, eng_abort, alarm, fault
  );

endinterface

// File: rtl/ids_channel_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or
// after ptr, wrapping at N.
module ids_channel_scheduler_rr_arbiter
  import ids_channel_scheduler_pkg::*;
#(
  parameter  int N = DEF_N_CH,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (W+1)'(k);
      if (pos >= (W+1)'(N))
        pos = pos - (W+1)'(N);
      if (!any && req[pos[W-1:0]]) begin
        any           = 1'b1;
        gnt[pos[W-1:0]] = 1'b1;
        idx           = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ids_channel_scheduler.sv
// Time-shares one IDS engine among N_CH CAN channels with a
// watchdog and per-channel alarm hysteresis.
module ids_channel_scheduler
  import ids_channel_scheduler_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int ALARM_K = DEF_ALARM_K,
  parameter int CLEAR_K = DEF_CLEAR_K,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  ids_channel_scheduler_if.master bus
);

  localparam int SW   = $clog2(N_CH);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int AW   = $clog2(ALARM_K + 1);
  localparam int CW   = $clog2(CLEAR_K + 1);

  sched_state_e    state;
  logic [SW-1:0]   rr_ptr;
  logic [WD_W-1:0] wd;

  logic [N_CH-1:0] arb_gnt;
  logic [SW-1:0]   arb_idx;
  logic            arb_any;

  verdict_t        verdict;
  logic            expire;
  logic [N_CH-1:0] alarm_vec;
  logic [N_CH-1:0] fault_vec;

  ids_channel_scheduler_rr_arbiter #(
    .N (N_CH)
  ) u_arb (
    .req (bus.ch_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // done on the expiry cycle wins over the watchdog
  always_comb begin
    expire          = (state == RUN) &&
                      (wd == WD_W'(TIMEOUT - 1));
    verdict.valid   = (state == RUN) && bus.eng_done;
    verdict.attack  = bus.eng_attack;
    verdict.aborted = expire && !bus.eng_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      wd            <= '0;
      bus.ch_gnt    <= '0;
      bus.ch_ack    <= '0;
      bus.ch_sel    <= '0;
      bus.eng_start <= 1'b0;
      bus.eng_abort <= 1'b0;
    end else begin
      bus.eng_start <= 1'b0;
      bus.eng_abort <= 1'b0;
      bus.ch_ack    <= '0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            bus.ch_sel    <= arb_idx;
            bus.ch_gnt    <= arb_gnt;
            bus.eng_start <= 1'b1;
            wd            <= '0;
            state         <= RUN;
          end
        end
        RUN: begin
          wd <= wd + 1'b1;
          if (verdict.valid || verdict.aborted) begin
            state         <= POST;
            bus.ch_ack    <= bus.ch_gnt;
            bus.ch_gnt    <= '0;
            bus.eng_abort <= verdict.aborted;
            if (bus.ch_sel == SW'(N_CH - 1))
              rr_ptr <= '0;
            else
              rr_ptr <= bus.ch_sel + 1'b1;
          end
        end
        POST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [AW-1:0] atk_cnt;
    logic [CW-1:0] clr_cnt;
    logic          alarm_q;
    logic          fault_q;
    logic          hit;

    assign hit = bus.ch_gnt[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        atk_cnt <= '0;
        clr_cnt <= '0;
        alarm_q <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        if (verdict.valid && hit) begin
          if (verdict.attack) begin
            clr_cnt <= '0;
            if (atk_cnt != AW'(ALARM_K))
              atk_cnt <= atk_cnt + 1'b1;
            if (atk_cnt >= AW'(ALARM_K - 1))
              alarm_q <= 1'b1;
          end else begin
            atk_cnt <= '0;
            if (clr_cnt != CW'(CLEAR_K))
              clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt >= CW'(CLEAR_K - 1))
              alarm_q <= 1'b0;
          end
        end
        if (verdict.aborted && hit)
          fault_q <= 1'b1;
        else if (bus.fault_clr[i])
          fault_q <= 1'b0;
      end
    end

    assign alarm_vec[i] = alarm_q;
    assign fault_vec[i] = fault_q;
  end

  assign bus.alarm = alarm_vec;
  assign bus.fault = fault_vec;

endmodule

// File: tb/tb_ids_channel_scheduler.sv
// Self-checking bench for ids_channel_scheduler: vector table,
// ack scoreboard, and hand sequences for watchdog and reset.
module tb_ids_channel_scheduler;
  import ids_channel_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ids_channel_scheduler_if #(.N_CH(N)) bus();

  ids_channel_scheduler #(
    .N_CH    (N),
    .ALARM_K (3),
    .CLEAR_K (2),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] req;
    int         dly;
    bit         atk;
    bit         hold;
    logic [3:0] gnt;
    int         lat;
    logic [3:0] alarm;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] alarm;
    logic [3:0] fault;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ch_ack != 4'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {28'b0, bus.ch_ack}, 32'b0);
      end else begin
        mon_e = sb.pop_front();
        check("ack", {28'b0, bus.ch_ack}, {28'b0, mon_e.ack});
        check("ack_alarm", {28'b0, bus.alarm},
              {28'b0, mon_e.alarm});
        check("ack_fault", {28'b0, bus.fault},
              {28'b0, mon_e.fault});
      end
    end
  end

  task automatic run_one(input vec_t v);
    int n;
    int aborts;
    bus.ch_req = v.req;
    sb.push_back(exp_t'{v.gnt, v.alarm, 4'b0});
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.eng_start && n < 20);
    check("start_lat", n, v.lat);
    check("gnt", {28'b0, bus.ch_gnt}, {28'b0, v.gnt});
    check("sel", {30'b0, bus.ch_sel}, oh_idx(v.gnt));
    aborts = 0;
    repeat (v.dly) begin
      tick();
      if (bus.eng_abort) aborts++;
    end
    bus.eng_done   = 1'b1;
    bus.eng_attack = v.atk;
    tick();
    bus.eng_done   = 1'b0;
    bus.eng_attack = 1'b0;
    if (bus.eng_abort) aborts++;
    check("no_abort", aborts, 0);
    if (!v.hold) bus.ch_req = 4'b0;
  endtask

  task automatic check_zero(string name);
    check({name, "_gnt"}, {28'b0, bus.ch_gnt}, 32'b0);
    check({name, "_ack"}, {28'b0, bus.ch_ack}, 32'b0);
    check({name, "_sel"}, {30'b0, bus.ch_sel}, 32'b0);
    check({name, "_start"}, {31'b0, bus.eng_start}, 32'b0);
    check({name, "_abort"}, {31'b0, bus.eng_abort}, 32'b0);
    check({name, "_alarm"}, {28'b0, bus.alarm}, 32'b0);
    check({name, "_fault"}, {28'b0, bus.fault}, 32'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    int k;
    bus.ch_req     = 4'b0;
    bus.eng_done   = 1'b0;
    bus.eng_attack = 1'b0;
    bus.fault_clr  = 4'b0;

    vecs[0]  = '{4'b0001, 10, 1'b1, 1'b0, 4'b0001, 1, 4'b0000};
    vecs[1]  = '{4'b1111, 0, 1'b0, 1'b1, 4'b0001, 1, 4'b0000};
    vecs[2]  = '{4'b1111, 1, 1'b0, 1'b1, 4'b0010, 2, 4'b0000};
    vecs[3]  = '{4'b1111, 2, 1'b0, 1'b1, 4'b0100, 2, 4'b0000};
    vecs[4]  = '{4'b1111, 3, 1'b0, 1'b1, 4'b1000, 2, 4'b0000};
    vecs[5]  = '{4'b1111, 0, 1'b0, 1'b0, 4'b0001, 2, 4'b0000};
    vecs[6]  = '{4'b0100, 0, 1'b1, 1'b1, 4'b0100, 2, 4'b0000};
    vecs[7]  = '{4'b0100, 4, 1'b1, 1'b1, 4'b0100, 2, 4'b0000};
    vecs[8]  = '{4'b0100, 0, 1'b1, 1'b1, 4'b0100, 2, 4'b0100};
    vecs[9]  = '{4'b0100, 0, 1'b0, 1'b1, 4'b0100, 2, 4'b0100};
    vecs[10] = '{4'b0100, 0, 1'b0, 1'b1, 4'b0100, 2, 4'b0000};
    vecs[11] = '{4'b0100, 0, 1'b1, 1'b1, 4'b0100, 2, 4'b0000};
    vecs[12] = '{4'b0100, 0, 1'b1, 1'b1, 4'b0100, 2, 4'b0000};
    vecs[13] = '{4'b0100, 0, 1'b1, 1'b0, 4'b0100, 2, 4'b0100};
    vecs[14] = '{4'b0011, 0, 1'b0, 1'b0, 4'b0001, 2, 4'b0100};
    vecs[15] = '{4'b1001, 0, 1'b0, 1'b0, 4'b1000, 2, 4'b0100};
    vecs[16] = '{4'b0010, TO-1, 1'b1, 1'b1, 4'b0010, 1, 4'b0100};
    vecs[17] = '{4'b0010, 0, 1'b1, 1'b1, 4'b0010, 2, 4'b0100};
    vecs[18] = '{4'b0010, 0, 1'b1, 1'b1, 4'b0010, 2, 4'b0110};
    vecs[19] = '{4'b1111, 0, 1'b0, 1'b0, 4'b0001, 1, 4'b0000};

    #12;
    check_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // single request, attack verdict after 10 cycles
    run_one(vecs[0]);

    // a stray done while idle must be ignored
    tick();
    tick();
    bus.eng_done   = 1'b1;
    bus.eng_attack = 1'b1;
    tick();
    bus.eng_done   = 1'b0;
    bus.eng_attack = 1'b0;
    check("idle_done_gnt", {28'b0, bus.ch_gnt}, 32'b0);
    check("idle_done_start", {31'b0, bus.eng_start}, 32'b0);
    tick();
    check("idle_done_ack", {28'b0, bus.ch_ack}, 32'b0);

    rst = 1'b1;
    tick();
    check_zero("rst2");
    rst = 1'b0;
    tick();

    for (int i = 1; i <= 15; i++)
      run_one(vecs[i]);

    // watchdog expiry on ch2 with its alarm set
    bus.ch_req = 4'b0100;
    sb.push_back(exp_t'{4'b0100, 4'b0100, 4'b0100});
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.eng_start && n < 20);
    check("wd_lat", n, 2);
    bus.ch_req = 4'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.eng_abort && k < TO + 10);
    check("abort_cycle", k, TO);
    check("abort_fault", {28'b0, bus.fault}, 32'h4);
    check("abort_alarm", {28'b0, bus.alarm}, 32'h4);
    tick();
    check("abort_pulse", {31'b0, bus.eng_abort}, 32'b0);
    check("fault_sticky", {28'b0, bus.fault}, 32'h4);
    bus.fault_clr = 4'b0100;
    tick();
    bus.fault_clr = 4'b0;
    check("fault_clr", {28'b0, bus.fault}, 32'b0);

    // done exactly on expiry, then build alarm on ch1
    for (int i = 16; i <= 18; i++)
      run_one(vecs[i]);

    // async reset in the middle of a run
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.eng_start && n < 20);
    check("mid_lat", n, 2);
    check("mid_gnt", {28'b0, bus.ch_gnt}, 32'h2);
    repeat (3) tick();
    check("pre_rst_alarm", {28'b0, bus.alarm}, 32'h6);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    bus.ch_req = 4'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_one(vecs[19]);

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
